// File: rtl/rx_arbiter.sv
// rx_arbiter: round-robin arbiter that lets NREQ requesters share one rx
// receiver through a single-entry output register. A grant lasts up to
// MAX_BURST accepted beats, or until the owner drops its valid. A sticky flag
// reports when the receiver has held off a pending beat for BUSY_LIMIT cycles.
module rx_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 3,
    parameter int MAX_BURST  = 4,
    parameter int BUSY_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rx_valid_o,
    output logic [DW-1:0]        rx_data_o,
    input  logic                 rx_ready_i,
    input  logic                 rx_busy_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 stall_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam int SW    = $clog2(BUSY_LIMIT + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Control state
    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [BW-1:0]    burst_q, burst_d;

    // Output register
    logic             rx_valid_q, rx_valid_d;
    logic [DW-1:0]    rx_data_q, rx_data_d;

    // Stall tracking
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic             stall_q, stall_d;

    // Per-requester views and arbitration helpers
    logic [DW-1:0]    req_data_arr [NREQ];
    logic [IDX_W-1:0] rr_dist [NREQ];
    logic [IDX_W:0]   best_dist;
    logic [IDX_W-1:0] pick_idx;

    logic             owner_valid;
    logic [DW-1:0]    owner_data;
    logic             xfer;
    logic             accept;
    logic             burst_last;
    logic             stall_cond;

    // rr_dist[k] is how far requester k sits after the last owner in the
    // rotation (0 = immediately next), so the smallest distance wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data_i[gi*DW +: DW];
            assign rr_dist[gi]      = IDX_W'((gi + NREQ - 1 - int'(last_owner_q)) % NREQ);
            assign req_ready_o[gi]  = accept && (owner_q == IDX_W'(gi));
        end
    endgenerate

    assign owner_valid = req_valid_i[owner_q];
    assign owner_data  = req_data_arr[owner_q];
    assign xfer        = rx_valid_q && rx_ready_i && !rx_busy_i;
    // Accept is gated by rst_n, so the reset cycle produces no accept.
    assign accept      = rst_n && (state_q == ST_GRANT) && owner_valid
                         && (!rx_valid_q || xfer);
    assign burst_last  = (burst_q == BW'(MAX_BURST - 1));
    assign stall_cond  = rx_valid_q && rx_busy_i;

    assign grant_o     = grant_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign stall_o     = stall_q;

    // Pick the valid requester closest after the previous owner.
    always_comb begin
        best_dist = (IDX_W+1)'(NREQ);
        pick_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid_i[i] && ({1'b0, rr_dist[i]} < best_dist)) begin
                best_dist = {1'b0, rr_dist[i]};
                pick_idx  = IDX_W'(i);
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_d      = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    burst_d = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    burst_d = burst_q + BW'(1);
                end
                // Release does not wait for the output register to drain.
                if (!owner_valid || (accept && burst_last)) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    burst_d      = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                burst_d = '0;
            end
        endcase
    end

    // Output register: load on accept, empty on a transfer with no refill.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (accept) begin
            rx_valid_d = 1'b1;
            rx_data_d  = owner_data;
        end else if (xfer) begin
            rx_valid_d = 1'b0;
        end
    end

    // Stall counter saturates at the limit; the flag latches once reached.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!stall_cond) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != SW'(BUSY_LIMIT)) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
        stall_d = stall_q || (stall_cnt_d == SW'(BUSY_LIMIT));
    end

    // Register control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
        end
    end

    // Register the output beat; reset discards any pending beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Register stall counter and sticky flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

endmodule
